// File: rtl/rng_collect_if.sv
// Valid/ready stream interface: the producer drives valid and data, the consumer drives ready.
`timescale 1ns/1ps
interface dti #(
  parameter int W = 17
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/rng_collect.sv
// Recovers {err, incr, cnt, base} from an eot-terminated arithmetic stream.
// Optional macro RNG_COLLECT_ERR_CNT_EN adds a saturating err_cnt output.
`timescale 1ns/1ps
module rng_collect #(
  parameter int W_DATA  = 16,
  parameter int W_INCR  = 16,
  parameter int W_CNT   = 16,
  parameter int W_START = 16,
  parameter bit SIGNED  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  dti.consumer        din,
  dti.producer        dout
`ifdef RNG_COLLECT_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int W_EXT = ((W_DATA + 1 > W_INCR) ? W_DATA + 1 : W_INCR) + 1;

  typedef enum logic [1:0] {
    FIRST  = 2'd0,
    SECOND = 2'd1,
    RUN    = 2'd2,
    OUT    = 2'd3
  } state_t;

  if ($bits(dout.data) != 1 + W_INCR + W_CNT + W_START || $bits(din.data) != 1 + W_DATA) begin : g_size_check
    $fatal(1, "rng_collect: interface data widths do not match parameters");
  end

  function automatic logic [W_EXT-1:0] ext_diff(input logic [W_DATA:0] d);
    return {{(W_EXT-W_DATA-1){d[W_DATA]}}, d};
  endfunction

  function automatic logic [W_EXT-1:0] ext_incr(input logic [W_INCR-1:0] v);
    if (SIGNED) return {{(W_EXT-W_INCR){v[W_INCR-1]}}, v};
    else        return {{(W_EXT-W_INCR){1'b0}}, v};
  endfunction

  function automatic logic [W_START-1:0] ext_base(input logic [W_DATA-1:0] d);
    if (SIGNED) return W_START'($signed(d));
    else        return W_START'(d);
  endfunction

  state_t              state_r;
  logic                valid_r;
  logic                ready_r;
  logic                err_r;
  logic [W_INCR-1:0]   incr_r;
  logic [W_CNT-1:0]    cnt_r;
  logic [W_START-1:0]  base_r;
  logic [W_DATA-1:0]   prev_r;

  logic [W_DATA-1:0]   data_s;
  logic                eot_s;
  logic                take_s;
  logic [W_DATA:0]     diff_s;
  logic [W_EXT-1:0]    diff_ext_s;
  logic [W_INCR-1:0]   incr_new_s;
  logic                fits_s;
  logic                neg_s;
  logic                match_s;
  logic                cnt_sat_s;

  assign data_s     = din.data[W_DATA-1:0];
  assign eot_s      = din.data[W_DATA];
  assign take_s     = din.valid & ready_r;
  assign diff_ext_s = ext_diff(diff_s);
  assign incr_new_s = W_INCR'(diff_ext_s);
  // A difference fits when truncating and re-extending it reproduces the same value.
  assign fits_s     = (ext_incr(incr_new_s) == diff_ext_s);
  assign neg_s      = !SIGNED && diff_s[W_DATA];
  assign match_s    = (ext_incr(incr_r) == diff_ext_s);
  assign cnt_sat_s  = (cnt_r == {W_CNT{1'b1}});

  assign din.ready  = ready_r;
  assign dout.valid = valid_r;
  assign dout.data  = {err_r, incr_r, cnt_r, base_r};

  // Difference between the incoming item and the previous one, one bit wider than the data.
  always_comb begin
    diff_s = '0;
    if (SIGNED) begin
      diff_s = {data_s[W_DATA-1], data_s} - {prev_r[W_DATA-1], prev_r};
    end else begin
      diff_s = {1'b0, data_s} - {1'b0, prev_r};
    end
  end

  // Collection state machine with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= FIRST;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
      err_r   <= 1'b0;
      incr_r  <= '0;
      cnt_r   <= '0;
      base_r  <= '0;
      prev_r  <= '0;
    end else begin
      case (state_r)
        FIRST: begin
          if (take_s) begin
            base_r  <= ext_base(data_s);
            prev_r  <= data_s;
            cnt_r   <= W_CNT'(1);
            incr_r  <= '0;
            err_r   <= 1'b0;
            state_r <= eot_s ? OUT : SECOND;
            valid_r <= eot_s;
            ready_r <= !eot_s;
          end
        end
        SECOND: begin
          if (take_s) begin
            incr_r  <= incr_new_s;
            cnt_r   <= cnt_r + W_CNT'(1);
            prev_r  <= data_s;
            if (!fits_s || neg_s) err_r <= 1'b1;
            state_r <= eot_s ? OUT : RUN;
            valid_r <= eot_s;
            ready_r <= !eot_s;
          end
        end
        RUN: begin
          if (take_s) begin
            if (!match_s || cnt_sat_s) err_r <= 1'b1;
            if (!cnt_sat_s) cnt_r <= cnt_r + W_CNT'(1);
            prev_r  <= data_s;
            state_r <= eot_s ? OUT : RUN;
            valid_r <= eot_s;
            ready_r <= !eot_s;
          end
        end
        OUT: begin
          if (dout.ready) begin
            state_r <= FIRST;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= FIRST;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef RNG_COLLECT_ERR_CNT_EN
  // Count accepted error reports, saturating at all ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 16'd0;
    end else if (valid_r && dout.ready && err_r && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/rng_collect.md
Name: rng_collect

Overview:
- Inverse of the range generator: consumes an eot-terminated stream of numbers and recovers the range config that produced it (base, incr, cnt).
- Emits one config word per input transaction, plus an error flag when the stream is not an arithmetic progression.
- Sits at the sink end of range streams, in checkers and in loopback tests where generated ranges are converted back to config words.

Parameters:
- W_DATA, 16, width of the din data field, excluding eot.
- W_INCR, 16, width of the recovered incr field.
- W_CNT, 16, width of the recovered cnt field (number of elements).
- W_START, 16, width of the recovered base field; must satisfy W_START >= W_DATA.
- SIGNED, 0, 1 = data and incr are two's complement.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- din  dti.consumer  1+W_DATA  stream item: {eot, data}, eot in MSB.
- dout  dti.producer  1+W_INCR+W_CNT+W_START  {err, incr, cnt, base}; base in the LSBs, err in the MSB.

Behaviour:
- Reset (rst=0, async): state=FIRST, dout.valid=0, all internal registers 0, err=0.
- Only din.valid & din.ready counts as an item.
- States and transitions:
  - FIRST:
    - base<=sign/zero-extend(data), prev<=data, cnt<=1, incr<=0, err<=0.
    - eot=1 -> OUT; otherwise -> SECOND.
  - SECOND:
    - diff = data - prev, computed in W_DATA+1 bits, signed per SIGNED.
    - incr<=diff truncated to W_INCR; cnt<=cnt+1; prev<=data.
    - err<=1 if diff is not representable in W_INCR (signed range when SIGNED=1).
    - err<=1 if SIGNED=0 and diff<0 (a descending unsigned sequence).
    - eot=1 -> OUT; otherwise -> RUN.
  - RUN:
    - Same diff computation. If diff != incr, set err (sticky).
    - cnt<=cnt+1, saturating at 2^W_CNT-1. An item arriving while cnt is already saturated sets err.
    - prev<=data. eot=1 -> OUT.
  - OUT:
    - dout.valid=1, din.ready=0.
    - dout.data stays stable until dout.valid & dout.ready; then -> FIRST.
- din.ready = 1 in FIRST, SECOND and RUN; 0 in OUT.
  - Throughput: one item per cycle, plus one bubble per transaction.
- Latency: dout.valid asserts the cycle after the eot item handshake.
- dout.valid is registered. dout.valid and din.ready are never combinationally dependent on dout.ready.
- Values reported when err=1:
  - incr = the first difference; cnt = the actual element count; base = the first element.
- Wrap-around:
  - Differences are computed mod 2^(W_DATA+1) before the range check. Unsigned 65535->0 gives diff=-65535, so err=1.
- Reset mid-transaction discards the partial sequence. The next item after reset release is treated as the first element.
- Usage check: an initial assertion fails with $fatal if $size(dout.data) != 1+W_INCR+W_CNT+W_START or $size(din.data) != 1+W_DATA.

Optional Feature:
- Macro: RNG_COLLECT_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt (16 bits).
  - err_cnt increments on each dout handshake with err=1 and saturates at 0xFFFF.
  - Cleared only by reset.
  - Port is registered, reset value 0.
- Undefined: no err_cnt port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Basic progression (SIGNED=0): din 3,5,7,9(eot=1) -> one dout {err=0, incr=2, cnt=4, base=3}; dout.valid exactly one cycle after the item 9 handshake.
- Single element: din 42(eot) -> {err=0, incr=0, cnt=1, base=42}.
- Non-arithmetic stream: din 0,1,3(eot) -> {err=1, incr=1, cnt=3, base=0}. With RNG_COLLECT_ERR_CNT_EN, err_cnt goes 0->1.
- Signed descending (SIGNED=1): din 10,7,4,1,-2(eot) -> {err=0, incr=0xFFFD, cnt=5, base=10}.
- Unsigned descending (SIGNED=0): din 5,4(eot) -> err=1.
- Backpressure: hold dout.ready=0 for 5 cycles after dout.valid -> din.ready=0 and dout.data unchanged throughout. Raise dout.ready -> next sequence 1,2(eot) is accepted starting the following cycle and yields {0,1,2,1}.
- Reset mid-sequence: send 3,5, pull rst low for 2 cycles (async, not clock-aligned) -> dout.valid=0 immediately. After release, sequence 8(eot) -> {0,0,1,8}.
